// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// The ALUOp/NPCOp/EXTOp/WDSel/DMType values are the single-cycle CPU encodings.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH
  } inst_class_e;

  // ALU operation codes
  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_LUI   = 5'd1;
  localparam logic [4:0] ALU_AUIPC = 5'd2;
  localparam logic [4:0] ALU_ADD   = 5'd3;
  localparam logic [4:0] ALU_SUB   = 5'd4;
  localparam logic [4:0] ALU_BNE   = 5'd5;
  localparam logic [4:0] ALU_BLT   = 5'd6;
  localparam logic [4:0] ALU_BGE   = 5'd7;
  localparam logic [4:0] ALU_BLTU  = 5'd8;
  localparam logic [4:0] ALU_BGEU  = 5'd9;
  localparam logic [4:0] ALU_SLT   = 5'd10;
  localparam logic [4:0] ALU_SLTU  = 5'd11;
  localparam logic [4:0] ALU_XOR   = 5'd12;
  localparam logic [4:0] ALU_OR    = 5'd13;
  localparam logic [4:0] ALU_AND   = 5'd14;
  localparam logic [4:0] ALU_SLL   = 5'd15;
  localparam logic [4:0] ALU_SRL   = 5'd16;
  localparam logic [4:0] ALU_SRA   = 5'd17;

  // Next-PC selection
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // Immediate extension, one-hot
  localparam logic [5:0] EXT_NONE   = 6'b000000;
  localparam logic [5:0] EXT_ISHIFT = 6'b100000;
  localparam logic [5:0] EXT_I      = 6'b010000;
  localparam logic [5:0] EXT_S      = 6'b001000;
  localparam logic [5:0] EXT_B      = 6'b000100;
  localparam logic [5:0] EXT_U      = 6'b000010;
  localparam logic [5:0] EXT_J      = 6'b000001;

  // Register write-data source
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // Data memory access width/sign
  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  // Major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [5:0]  ext_op;
    logic [4:0]  alu_op;
    logic        alu_src;
    logic [1:0]  wd_sel;
    logic [2:0]  dm_type;
    logic [2:0]  npc_op;
    inst_class_e cls;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NOP = '0;

  // Load/store funct3 to DMType
  function automatic logic [2:0] dm_type_of(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return DM_B;
      3'b001:  return DM_H;
      3'b100:  return DM_BU;
      3'b101:  return DM_HU;
      default: return DM_W;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational RV32I decoder: opcode/funct fields to control word, class and
// an illegal flag. An illegal encoding always yields the all-zero control word.
module mc_ctrl_dec import mc_ctrl_pkg::*; (
  input  logic [6:0] op_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output ctrl_word_t cw_o,
  output logic       illegal_o
);

  // Decode the instruction fields into a control word
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    cw_o      = CW_NOP;
    illegal_o = 1'b0;
    case (op_i)
      OPC_R: begin
        cw_o.cls = CLS_ALU;
        case ({funct7_i, funct3_i})
          {7'b0000000, 3'b000}: cw_o.alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: cw_o.alu_op = ALU_SUB;
          {7'b0000000, 3'b001}: cw_o.alu_op = ALU_SLL;
          {7'b0000000, 3'b010}: cw_o.alu_op = ALU_SLT;
          {7'b0000000, 3'b011}: cw_o.alu_op = ALU_SLTU;
          {7'b0000000, 3'b100}: cw_o.alu_op = ALU_XOR;
          {7'b0000000, 3'b101}: cw_o.alu_op = ALU_SRL;
          {7'b0100000, 3'b101}: cw_o.alu_op = ALU_SRA;
          {7'b0000000, 3'b110}: cw_o.alu_op = ALU_OR;
          {7'b0000000, 3'b111}: cw_o.alu_op = ALU_AND;
          default:              illegal_o   = 1'b1;
        endcase
      end
      OPC_I: begin
        cw_o.cls     = CLS_ALU;
        cw_o.alu_src = 1'b1;
        cw_o.ext_op  = EXT_I;
        case (funct3_i)
          3'b000: cw_o.alu_op = ALU_ADD;
          3'b010: cw_o.alu_op = ALU_SLT;
          3'b011: cw_o.alu_op = ALU_SLTU;
          3'b100: cw_o.alu_op = ALU_XOR;
          3'b110: cw_o.alu_op = ALU_OR;
          3'b111: cw_o.alu_op = ALU_AND;
          3'b001: begin
            cw_o.ext_op = EXT_ISHIFT;
            cw_o.alu_op = ALU_SLL;
            illegal_o   = (funct7_i != 7'b0000000);
          end
          default: begin // 3'b101: srli / srai
            cw_o.ext_op = EXT_ISHIFT;
            if (funct7_i == 7'b0000000)      cw_o.alu_op = ALU_SRL;
            else if (funct7_i == 7'b0100000) cw_o.alu_op = ALU_SRA;
            else                             illegal_o   = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        cw_o.cls     = CLS_LOAD;
        cw_o.alu_src = 1'b1;
        cw_o.ext_op  = EXT_I;
        cw_o.alu_op  = ALU_ADD;
        cw_o.wd_sel  = WD_MEM;
        cw_o.dm_type = dm_type_of(funct3_i);
        illegal_o    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
      end
      OPC_STORE: begin
        cw_o.cls     = CLS_STORE;
        cw_o.alu_src = 1'b1;
        cw_o.ext_op  = EXT_S;
        cw_o.alu_op  = ALU_ADD;
        cw_o.dm_type = dm_type_of(funct3_i);
        illegal_o    = (funct3_i[2] == 1'b1) || (funct3_i == 3'b011);
      end
      OPC_BRANCH: begin
        cw_o.cls    = CLS_BRANCH;
        cw_o.ext_op = EXT_B;
        cw_o.npc_op = NPC_BRANCH;
        case (funct3_i)
          3'b000:  cw_o.alu_op = ALU_SUB;
          3'b001:  cw_o.alu_op = ALU_BNE;
          3'b100:  cw_o.alu_op = ALU_BLT;
          3'b101:  cw_o.alu_op = ALU_BGE;
          3'b110:  cw_o.alu_op = ALU_BLTU;
          3'b111:  cw_o.alu_op = ALU_BGEU;
          default: illegal_o   = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        cw_o.cls     = CLS_ALU;
        cw_o.alu_src = 1'b1;
        cw_o.ext_op  = EXT_U;
        cw_o.alu_op  = (op_i == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
      end
      OPC_JAL: begin
        cw_o.cls    = CLS_ALU;
        cw_o.ext_op = EXT_J;
        cw_o.wd_sel = WD_PC;
        cw_o.npc_op = NPC_JUMP;
      end
      OPC_JALR: begin
        cw_o.cls     = CLS_ALU;
        cw_o.alu_src = 1'b1;
        cw_o.ext_op  = EXT_I;
        cw_o.alu_op  = ALU_ADD;
        cw_o.wd_sel  = WD_PC;
        cw_o.npc_op  = NPC_JALR;
        illegal_o    = (funct3_i != 3'b000);
      end
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) cw_o = CW_NOP;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory handshakes, registered control word and optional bus timeout.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on illegal instructions; otherwise
// they retire as a nop.
module mc_ctrl import mc_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  output logic       i_req,
  input  logic       i_ack,
  output logic       d_req,
  input  logic       d_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic [5:0] EXTOp,
  output logic [4:0] ALUOp,
  output logic [2:0] NPCOp,
  output logic [1:0] WDSel,
  output logic [2:0] DMType,
  output logic       trap,
  output logic       bus_err
);

  // Counter only needs to reach TIMEOUT_CYC-1: the limit cycle itself is decisive.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  ctrl_word_t       cw_q, cw_d, dec_cw;
  logic             dec_illegal;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d, bus_err_q, bus_err_d;
  logic             timeout_hit;

  mc_ctrl_dec u_dec (
    .op_i      (Op),
    .funct7_i  (Funct7),
    .funct3_i  (Funct3),
    .cw_o      (dec_cw),
    .illegal_o (dec_illegal)
  );

  assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt_q == CNT_LIMIT);

  // Next state, handshake requests and write strobes
  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    cnt_d     = '0;
    trap_d    = trap_q;
    bus_err_d = bus_err_q;
    i_req     = 1'b0;
    d_req     = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    NPCOp     = NPC_PLUS4;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        i_req = 1'b1;
        if (i_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        cw_d = dec_cw;
        if (dec_illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          trap_d  = 1'b1;
          state_d = ST_TRAP;
`else
          pc_we   = 1'b1;
          NPCOp   = NPC_PLUS4;
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cw_q.cls)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        d_req    = 1'b1;
        MemWrite = (cw_q.cls == CLS_STORE);
        if (d_ack) begin
          if (cw_q.cls == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        pc_we    = 1'b1;
        NPCOp    = cw_q.npc_op;
        state_d  = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RST;
    endcase
  end

  // State, control word, timeout counter and sticky fault flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RST;
      cw_q      <= CW_NOP;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cw_q      <= cw_d;
      cnt_q     <= cnt_d;
      trap_q    <= trap_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign ALUSrc  = cw_q.alu_src;
  assign EXTOp   = cw_q.ext_op;
  assign ALUOp   = cw_q.alu_op;
  assign WDSel   = cw_q.wd_sel;
  assign DMType  = cw_q.dm_type;
  assign trap    = trap_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl with TIMEOUT_CYC=4: per-cycle vector table
// plus hand sequences for illegal opcode, bus timeout and reset mid-wait.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] Op = '0, Funct7 = '0;
  logic [2:0] Funct3 = '0;
  logic       Zero = 1'b0, i_ack = 1'b0, d_ack = 1'b0;
  logic       i_req, d_req, ir_we, pc_we, RegWrite, MemWrite, ALUSrc, trap, bus_err;
  logic [5:0] EXTOp;
  logic [4:0] ALUOp;
  logic [2:0] NPCOp, DMType;
  logic [1:0] WDSel;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero),
    .i_req(i_req), .i_ack(i_ack), .d_req(d_req), .d_ack(d_ack),
    .ir_we(ir_we), .pc_we(pc_we), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .WDSel(WDSel), .DMType(DMType), .trap(trap), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // {i_req,d_req,ir_we,pc_we,RegWrite,MemWrite,NPCOp,trap,bus_err}
  logic [10:0] act_s;
  // {ALUSrc,EXTOp,ALUOp,WDSel,DMType}
  logic [16:0] act_cw;
  assign act_s  = {i_req, d_req, ir_we, pc_we, RegWrite, MemWrite, NPCOp, trap, bus_err};
  assign act_cw = {ALUSrc, EXTOp, ALUOp, WDSel, DMType};

  // Strobe patterns {i_req,d_req,ir_we,pc_we,RegWrite,MemWrite,NPCOp}
  localparam logic [8:0] S_IDLE  = 9'b000000_000;
  localparam logic [8:0] S_F_ACK = 9'b101000_000;
  localparam logic [8:0] S_F_WT  = 9'b100000_000;
  localparam logic [8:0] S_WB4   = 9'b000110_000;
  localparam logic [8:0] S_WBJ   = 9'b000110_010;
  localparam logic [8:0] S_WBR   = 9'b000110_100;
  localparam logic [8:0] S_M_LD  = 9'b010000_000;
  localparam logic [8:0] S_M_ST  = 9'b010001_000;
  localparam logic [8:0] S_M_STA = 9'b010101_000;
  localparam logic [8:0] S_BR_T  = 9'b000100_001;
  localparam logic [8:0] S_BR_N  = 9'b000100_000;
  localparam logic [8:0] S_PC4   = 9'b000100_000;

  // Expected control words {ALUSrc,EXTOp,ALUOp,WDSel,DMType}
  localparam logic [16:0] CW_ZERO = 17'b0;
  localparam logic [16:0] CW_ADD  = {1'b0, 6'b000000, 5'b00011, 2'b00, 3'b000};
  localparam logic [16:0] CW_LW   = {1'b1, 6'b010000, 5'b00011, 2'b01, 3'b000};
  localparam logic [16:0] CW_SB   = {1'b1, 6'b001000, 5'b00011, 2'b00, 3'b011};
  localparam logic [16:0] CW_BEQ  = {1'b0, 6'b000100, 5'b00100, 2'b00, 3'b000};
  localparam logic [16:0] CW_SRAI = {1'b1, 6'b100000, 5'b10001, 2'b00, 3'b000};
  localparam logic [16:0] CW_LUI  = {1'b1, 6'b000010, 5'b00001, 2'b00, 3'b000};
  localparam logic [16:0] CW_JAL  = {1'b0, 6'b000001, 5'b00000, 2'b10, 3'b000};
  localparam logic [16:0] CW_JALR = {1'b1, 6'b010000, 5'b00011, 2'b10, 3'b000};

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_SB   = 32'h00208023; // sb   x2,0(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] I_SRAI = 32'h4020D193; // srai x3,x1,2
  localparam logic [31:0] I_LUI  = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] I_JAL  = 32'h010000EF; // jal  x1,16
  localparam logic [31:0] I_JALR = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z, ia, da;
    logic [8:0]  exp_s;
    logic        chk;
    logic [16:0] exp_cw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [31:0] ins, input logic z,
                              input logic ia, input logic da, input logic [8:0] es,
                              input logic c, input logic [16:0] ecw);
    vec_t v;
    v.name = n; v.ins = ins; v.z = z; v.ia = ia; v.da = da;
    v.exp_s = es; v.chk = c; v.exp_cw = ecw;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, compare mid-cycle, advance to next posedge+1.
  task automatic run_cycle(input string nm, input logic [31:0] ins, input logic z,
                           input logic ia, input logic da, input logic [10:0] es,
                           input logic c, input logic [16:0] ecw);
    Op = ins[6:0]; Funct3 = ins[14:12]; Funct7 = ins[31:25];
    Zero = z; i_ack = ia; d_ack = da;
    @(negedge clk);
    check(nm, {21'b0, act_s}, {21'b0, es});
    if (c) check({nm, "_cw"}, {15'b0, act_cw}, {15'b0, ecw});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_ack = 1'b0; d_ack = 1'b0; Zero = 1'b0;
    @(negedge clk);
    check("rst_strobes", {21'b0, act_s}, 32'b0);
    check("rst_cw", {15'b0, act_cw}, 32'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // add, ALU timing from reset release
    vecs.push_back(mk("add_rst", I_ADD, 0, 1, 0, S_IDLE,  1, CW_ZERO));
    vecs.push_back(mk("add_f",   I_ADD, 0, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("add_d",   I_ADD, 0, 1, 0, S_IDLE,  1, CW_ZERO));
    vecs.push_back(mk("add_e",   I_ADD, 0, 1, 0, S_IDLE,  1, CW_ADD));
    vecs.push_back(mk("add_wb",  I_ADD, 0, 1, 0, S_WB4,   1, CW_ADD));
    // lw, d_ack delayed 3 cycles (ack lands on the timeout limit); stray d_ack early is ignored
    vecs.push_back(mk("lw_f",    I_LW,  0, 1, 1, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("lw_d",    I_LW,  0, 1, 1, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("lw_e",    I_LW,  0, 1, 1, S_IDLE,  1, CW_LW));
    vecs.push_back(mk("lw_m1",   I_LW,  0, 1, 0, S_M_LD,  0, CW_ZERO));
    vecs.push_back(mk("lw_m2",   I_LW,  0, 1, 0, S_M_LD,  0, CW_ZERO));
    vecs.push_back(mk("lw_m3",   I_LW,  0, 1, 0, S_M_LD,  0, CW_ZERO));
    vecs.push_back(mk("lw_m4",   I_LW,  0, 1, 1, S_M_LD,  1, CW_LW));
    vecs.push_back(mk("lw_wb",   I_LW,  0, 1, 0, S_WB4,   1, CW_LW));
    // sb, one data wait state
    vecs.push_back(mk("sb_f",    I_SB,  0, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("sb_d",    I_SB,  0, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("sb_e",    I_SB,  0, 1, 0, S_IDLE,  1, CW_SB));
    vecs.push_back(mk("sb_m1",   I_SB,  0, 1, 0, S_M_ST,  1, CW_SB));
    vecs.push_back(mk("sb_m2",   I_SB,  0, 1, 1, S_M_STA, 1, CW_SB));
    // beq taken, then not taken (Zero only matters in EXEC)
    vecs.push_back(mk("beqt_f",  I_BEQ, 1, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("beqt_d",  I_BEQ, 1, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("beqt_e",  I_BEQ, 1, 1, 0, S_BR_T,  1, CW_BEQ));
    vecs.push_back(mk("beqn_f",  I_BEQ, 1, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("beqn_d",  I_BEQ, 1, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("beqn_e",  I_BEQ, 0, 1, 0, S_BR_N,  1, CW_BEQ));
    // srai with two fetch wait states
    vecs.push_back(mk("srai_f1", I_SRAI, 0, 0, 0, S_F_WT,  0, CW_ZERO));
    vecs.push_back(mk("srai_f2", I_SRAI, 0, 0, 1, S_F_WT,  0, CW_ZERO));
    vecs.push_back(mk("srai_f3", I_SRAI, 0, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("srai_d",  I_SRAI, 0, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("srai_e",  I_SRAI, 0, 1, 0, S_IDLE,  1, CW_SRAI));
    vecs.push_back(mk("srai_wb", I_SRAI, 0, 1, 0, S_WB4,   1, CW_SRAI));
    // lui, jal, jalr
    vecs.push_back(mk("lui_f",   I_LUI,  0, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("lui_d",   I_LUI,  0, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("lui_e",   I_LUI,  0, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("lui_wb",  I_LUI,  0, 1, 0, S_WB4,   1, CW_LUI));
    vecs.push_back(mk("jal_f",   I_JAL,  0, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("jal_d",   I_JAL,  0, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("jal_e",   I_JAL,  0, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("jal_wb",  I_JAL,  0, 1, 0, S_WBJ,   1, CW_JAL));
    vecs.push_back(mk("jalr_f",  I_JALR, 0, 1, 0, S_F_ACK, 0, CW_ZERO));
    vecs.push_back(mk("jalr_d",  I_JALR, 0, 1, 0, S_IDLE,  0, CW_ZERO));
    vecs.push_back(mk("jalr_e",  I_JALR, 0, 1, 0, S_IDLE,  1, CW_JALR));
    vecs.push_back(mk("jalr_wb", I_JALR, 0, 1, 0, S_WBR,   1, CW_JALR));

    do_reset();
    for (int i = 0; i < vecs.size(); i++)
      run_cycle(vecs[i].name, vecs[i].ins, vecs[i].z, vecs[i].ia, vecs[i].da,
                {vecs[i].exp_s, 2'b00}, vecs[i].chk, vecs[i].exp_cw);

    // Illegal opcode 0x7F
    run_cycle("ill_f", I_ILL, 0, 1, 0, {S_F_ACK, 2'b00}, 0, CW_ZERO);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    run_cycle("ill_d", I_ILL, 0, 1, 0, {S_IDLE, 2'b00}, 0, CW_ZERO);
    for (int i = 0; i < 3; i++)
      run_cycle("ill_trap", I_ADD, 0, 1, 1, {S_IDLE, 2'b10}, 0, CW_ZERO);
`else
    run_cycle("ill_d", I_ILL, 0, 1, 0, {S_PC4, 2'b00}, 0, CW_ZERO);
    run_cycle("ill_next_f", I_ADD, 0, 1, 0, {S_F_ACK, 2'b00}, 0, CW_ZERO);
`endif

    // Fetch timeout: no i_ack for 4 request cycles
    do_reset();
    run_cycle("to_rst", I_ADD, 0, 0, 0, {S_IDLE, 2'b00}, 0, CW_ZERO);
    for (int i = 0; i < 4; i++)
      run_cycle("to_fetch", I_ADD, 0, 0, 0, {S_F_WT, 2'b00}, 0, CW_ZERO);
    for (int i = 0; i < 3; i++)
      run_cycle("to_trap", I_ADD, 0, 1, 1, {S_IDLE, 2'b01}, 0, CW_ZERO);

    // Reset asserted in the middle of a pending data request
    do_reset();
    run_cycle("mr_rst", I_LW, 0, 1, 0, {S_IDLE, 2'b00}, 0, CW_ZERO);
    run_cycle("mr_f",   I_LW, 0, 1, 0, {S_F_ACK, 2'b00}, 0, CW_ZERO);
    run_cycle("mr_d",   I_LW, 0, 1, 0, {S_IDLE, 2'b00}, 0, CW_ZERO);
    run_cycle("mr_e",   I_LW, 0, 1, 0, {S_IDLE, 2'b00}, 1, CW_LW);
    run_cycle("mr_m1",  I_LW, 0, 1, 0, {S_M_LD, 2'b00}, 1, CW_LW);
    d_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mr_async_strobes", {21'b0, act_s}, 32'b0);
    check("mr_async_cw", {15'b0, act_cw}, 32'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_cycle("mr_rel_rst", I_LW, 0, 1, 0, {S_IDLE, 2'b00}, 1, CW_ZERO);
    run_cycle("mr_rel_f",   I_LW, 0, 1, 0, {S_F_ACK, 2'b00}, 0, CW_ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
